// File: rtl/divisor_pkg.sv
// Constant helpers that derive the divide ratio and phase lengths from the
// input and output clock frequencies.
package divisor_pkg;

    function automatic int unsigned div_n(input int unsigned f, input int unsigned r);
        return (r == 0) ? 0 : f / r;
    endfunction

    function automatic int unsigned div_low(input int unsigned f, input int unsigned r);
        return div_n(f, r) / 2;
    endfunction

    // Odd ratios give the spare cycle to the high phase.
    function automatic int unsigned div_high(input int unsigned f, input int unsigned r);
        return div_n(f, r) - div_low(f, r);
    endfunction

    function automatic int unsigned div_cnt_width(input int unsigned f, input int unsigned r);
        int unsigned h;
        h = div_high(f, r);
        return (h <= 1) ? 1 : $clog2(h);
    endfunction

endpackage

// File: rtl/divisor_counter.sv
// Phase counter: counts up from zero and clears itself when it reaches the
// loaded terminal value (phase length minus one).
module divisor_counter #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] i_len_m1,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc    = (r_count == i_len_m1);
    assign o_count = r_count;

endmodule

// File: rtl/divisor.sv
// Clock divider: Clk_out = Clk_in / (frecuency / reference_clocck), low phase
// first. Define DIVISOR_TICK_EN to add the registered Clk_tick rise pulse.
module divisor
    import divisor_pkg::*;
#(
    parameter int unsigned frecuency       = 50000000,
    parameter int unsigned reference_clocck = 1000000
) (
    input  logic Clk_in,
    input  logic reset,
    output logic Clk_out
`ifdef DIVISOR_TICK_EN
    ,
    output logic Clk_tick
`endif
);

    localparam int unsigned N    = div_n(frecuency, reference_clocck);
    localparam int unsigned LOW  = div_low(frecuency, reference_clocck);
    localparam int unsigned HIGH = div_high(frecuency, reference_clocck);
    localparam int unsigned CW   = div_cnt_width(frecuency, reference_clocck);

    if (reference_clocck == 0 || N < 2) begin : g_bad_ratio
        $fatal(1, "divisor: divide ratio %0d invalid (need reference_clocck > 0 and N >= 2)", N);
    end

    logic          r_clk_out;
    logic [CW-1:0] w_len_m1;
    logic [CW-1:0] w_count;
    logic          w_tc;

    // Terminal value follows the phase the output flop is currently in.
    assign w_len_m1 = r_clk_out ? CW'(HIGH - 1) : CW'(LOW - 1);

    divisor_counter #(.CW(CW)) u_cnt (
        .clk      (Clk_in),
        .rst      (reset),
        .i_len_m1 (w_len_m1),
        .o_count  (w_count),
        .o_tc     (w_tc)
    );

    always_ff @(posedge Clk_in) begin
        if (reset) begin
            r_clk_out <= 1'b0;
        end else if (w_tc) begin
            r_clk_out <= ~r_clk_out;
        end
    end

    assign Clk_out = r_clk_out;

    always_comb begin
        assert (w_count <= CW'(HIGH - 1));
    end

`ifdef DIVISOR_TICK_EN
    logic r_tick;

    // Fires on the same edge that raises Clk_out.
    always_ff @(posedge Clk_in) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tc & ~r_clk_out;
        end
    end

    assign Clk_tick = r_tick;
`endif

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: N=50 (defaults) and N=5 instances against
// a cycle-count reference model, plus fixed vectors and timing sequences.
`timescale 1ns/1ps
module tb_divisor;

    logic clk = 1'b0;
    logic rst50, rst5;
    logic out50, out5;
`ifdef DIVISOR_TICK_EN
    logic tick50, tick5;
`endif

    int nvec = 0;
    int nerr = 0;
    int unsigned k50 = 0;
    int unsigned k5  = 0;

    always #10 clk = ~clk;

    divisor dut50 (
        .Clk_in  (clk),
        .reset   (rst50),
        .Clk_out (out50)
`ifdef DIVISOR_TICK_EN
        ,
        .Clk_tick(tick50)
`endif
    );

    divisor #(.frecuency(10), .reference_clocck(2)) dut5 (
        .Clk_in  (clk),
        .reset   (rst5),
        .Clk_out (out5)
`ifdef DIVISOR_TICK_EN
        ,
        .Clk_tick(tick5)
`endif
    );

    // k = number of non-reset edges since reset was last sampled high.
    function automatic logic ref_out(input int unsigned k, input int unsigned n);
        int unsigned lo, hi;
        lo = n / 2;
        hi = n - lo;
        if (k < lo) return 1'b0;
        return (((k - lo) % n) < hi);
    endfunction

    function automatic logic ref_tick(input int unsigned k, input int unsigned n);
        int unsigned lo;
        lo = n / 2;
        if (k < lo || k == 0) return 1'b0;
        return (((k - lo) % n) == 0);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst50) k50 = 0; else k50++;
        if (rst5)  k5  = 0; else k5++;
        #1;
        chk("out50", out50, ref_out(k50, 50));
        chk("out5",  out5,  ref_out(k5, 5));
`ifdef DIVISOR_TICK_EN
        chk("tick50", tick50, ref_tick(k50, 50));
        chk("tick5",  tick5,  ref_tick(k5, 5));
`endif
    endtask

    typedef struct {
        logic rst;
        logic exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int e;
        longint t_r1, t_f, t_r2;

        tbl = '{'{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b0, 1'b1},
                '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b0, 1'b0}, '{1'b0, 1'b0},
                '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{1'b0, 1'b0},
                '{1'b0, 1'b1}, '{1'b0, 1'b1}};

        rst50 = 1'b1;
        rst5  = 1'b1;
        step();
        step();
        chk("reset_out50", out50, 1'b0);
        chk("reset_out5",  out5,  1'b0);
        chk_int("reset_cnt50", int'(dut50.w_count), 0);

        // N=5: low 2, high 3, reset mid-high aborts the pulse
        for (int i = 0; i < 14; i++) begin
            rst5 = tbl[i].rst;
            step();
            chk("tbl5", out5, tbl[i].exp);
        end

        // Defaults: first rise 25 edges after release, 500 ns high, 1000 ns period
        rst50 = 1'b1;
        step();
        step();
        rst50 = 1'b0;
        e = 0;
        do begin
            step();
            e++;
        end while (out50 !== 1'b1 && e < 100);
        chk_int("first_rise50", e, 25);
        t_r1 = $time;
        e = 0;
        while (out50 === 1'b1 && e < 100) begin step(); e++; end
        t_f = $time;
        while (out50 === 1'b0 && e < 200) begin step(); e++; end
        t_r2 = $time;
        chk_int("high_ns",   int'(t_f - t_r1),  500);
        chk_int("period_ns", int'(t_r2 - t_r1), 1000);

        // Reset while high at count 10
        rst50 = 1'b1;
        step();
        rst50 = 1'b0;
        repeat (35) step();
        chk("mid_high50", out50, 1'b1);
        chk_int("mid_cnt50", int'(dut50.w_count), 10);
        rst50 = 1'b1;
        step();
        chk("abort_out50", out50, 1'b0);
        chk_int("abort_cnt50", int'(dut50.w_count), 0);
        rst50 = 1'b0;
        e = 0;
        do begin
            step();
            e++;
        end while (out50 !== 1'b1 && e < 100);
        chk_int("rerise50", e, 25);

        // Reset held for 1000 cycles
        rst50 = 1'b1;
        rst5  = 1'b1;
        repeat (1000) step();
        chk("held_out50", out50, 1'b0);
        chk("held_out5",  out5,  1'b0);

        // Random reset pulses against the model
        for (int i = 0; i < 4000; i++) begin
            rst50 = ($urandom_range(0, 199) == 0);
            rst5  = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 The module SHALL have parameter frecuency, default 50000000, meaning the input clock frequency in Hz.
REQ-002 The module SHALL have parameter reference_clocck, default 1000000, meaning the desired output clock frequency in Hz.
REQ-003 Clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Clk_out  output  1  divided clock, registered.
REQ-006 Clk_tick  output  1  one-cycle pulse; present only with DIVISOR_TICK_EN (see Configuration).

Function
REQ-007 The divide ratio SHALL be N = frecuency / reference_clocck, using integer truncation; defaults give N = 50.
REQ-008 The low phase SHALL be LOW = floor(N/2) Clk_in cycles; the high phase SHALL be HIGH = N - LOW cycles. For odd N, the extra cycle SHALL go to the high phase.
REQ-009 An internal phase counter SHALL be $clog2(HIGH) bits wide, and at least 1 bit.
REQ-010 On each non-reset rising edge, if the counter equals the current phase length - 1, the counter SHALL clear and Clk_out SHALL toggle; otherwise the counter SHALL increment.
REQ-011 Current phase length SHALL be LOW while Clk_out = 0 and HIGH while Clk_out = 1.
REQ-012 After reset deasserts, Clk_out SHALL first rise on the LOW-th rising Clk_in edge. Thereafter Clk_out SHALL have a period of exactly N Clk_in cycles.
REQ-013 Clk_out SHALL be driven directly from a flop, with no combinational logic on the output.
REQ-014 The counter SHALL never exceed HIGH - 1; wrap-around SHALL occur only through the clear in REQ-010.
REQ-015 Elaboration SHALL fail (fatal) if reference_clocck = 0 or N < 2.

Reset
REQ-016 While reset is sampled high on a Clk_in rising edge, the counter SHALL be 0, Clk_out SHALL be 0 and Clk_tick SHALL be 0.
REQ-017 Reset asserted mid-period SHALL abort the current phase on that edge. No partial high pulse SHALL be extended.
REQ-018 Holding reset high continuously SHALL hold Clk_out at 0 indefinitely.

Configuration
REQ-019 Macro DIVISOR_TICK_EN defined: port Clk_tick SHALL exist.
REQ-020 With DIVISOR_TICK_EN, Clk_tick SHALL be registered and high for exactly one Clk_in cycle, coincident with the cycle in which Clk_out first reads 1 after a 0-to-1 toggle.
REQ-021 Macro DIVISOR_TICK_EN undefined: port Clk_tick and its logic SHALL be absent. Clk_out behaviour SHALL be identical in both builds.

Structure
REQ-022 Package divisor_pkg SHALL hold constant functions computing N, LOW, HIGH and the counter width from the two parameters.
REQ-023 The phase counter SHALL be a sub-module divisor_counter with inputs clk, sync reset, load-length; outputs count and a terminal-count flag.
REQ-024 The top level SHALL hold the Clk_out toggle flop, the optional tick flop and the elaboration checks.

Verification
REQ-025 Default parameters, Clk_in period 20 ns, reset high for 2 edges then low -> Clk_out rises 25 edges after release; period 1000 ns; 500 ns high / 500 ns low.
REQ-026 frecuency=10, reference_clocck=2 (N=5) -> Clk_out low 2 cycles, high 3 cycles, repeating.
REQ-027 Reset reasserted while Clk_out = 1 at count 10 -> Clk_out = 0 and counter = 0 on that edge. After release, the first rise is again 25 edges later.
REQ-028 Reset held high for 1000 cycles -> Clk_out constant 0.
REQ-029 DIVISOR_TICK_EN defined, defaults -> exactly one Clk_tick pulse per 50 cycles, aligned with each Clk_out rise. Undefined -> identical Clk_out waveform.
REQ-030 reference_clocck > frecuency/2 (N=1) -> elaboration fatal error.
